// File: rtl/multicycle_mem_bridge.sv
// Request/acknowledge bridge between the multicycle controller and a variable-latency memory bus,
// with RISC-V byte/halfword lane steering. Optional bus watchdog: define MEM_BRIDGE_TIMEOUT_EN.
module multicycle_mem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read_enable,
    input  logic        mem_write_enable,
    input  logic        inst_or_data,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic [31:0] store_data,
    input  logic [2:0]  funct3,
    output logic        stall,
    output logic [31:0] read_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
`ifdef MEM_BRIDGE_TIMEOUT_EN
    ,
    output logic        bus_error
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic        w_capture;
    logic        w_complete;
    logic        w_timeout;
    logic        w_timeoutHit;

    logic [31:0] w_addr;
    logic [2:0]  w_accessF3;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;

    logic        r_busReq;
    logic        r_busWe;
    logic [31:0] r_busAddr;
    logic [31:0] r_busWdata;
    logic [3:0]  r_busWstrb;
    logic [1:0]  r_lane;
    logic [2:0]  r_funct3;
    logic [31:0] r_readData;

    logic [7:0]  w_laneByte;
    logic [15:0] w_laneHalf;
    logic [31:0] w_loadValue;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // DONE ignores the enables so the strobe still held by the controller cannot re-issue.
    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        stall       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_read_enable || mem_write_enable) begin
                    w_capture   = 1'b1;
                    stall       = 1'b1;
                    w_nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (bus_ack) begin
                    w_complete  = 1'b1;
                    w_nextState = ST_DONE;
                end else if (w_timeoutHit) begin
                    w_timeout   = 1'b1;
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Fetches are always word accesses regardless of funct3.
    assign w_addr     = inst_or_data ? alu_out : pc;
    assign w_accessF3 = inst_or_data ? funct3 : 3'b010;

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = 32'h0000_0000;
        if (mem_write_enable) begin
            case (w_accessF3)
                3'b000: begin
                    w_wstrb = 4'b0001 << w_addr[1:0];
                    w_wdata = {4{store_data[7:0]}};
                end
                3'b001: begin
                    w_wstrb = 4'b0011 << {w_addr[1], 1'b0};
                    w_wdata = {2{store_data[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = store_data;
                end
            endcase
        end
    end

    always_comb begin
        w_laneByte  = bus_rdata[7:0];
        w_laneHalf  = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        w_loadValue = bus_rdata;
        case (r_lane)
            2'd0:    w_laneByte = bus_rdata[7:0];
            2'd1:    w_laneByte = bus_rdata[15:8];
            2'd2:    w_laneByte = bus_rdata[23:16];
            default: w_laneByte = bus_rdata[31:24];
        endcase
        case (r_funct3)
            3'b000:  w_loadValue = {{24{w_laneByte[7]}}, w_laneByte};
            3'b001:  w_loadValue = {{16{w_laneHalf[15]}}, w_laneHalf};
            3'b100:  w_loadValue = {24'h00_0000, w_laneByte};
            3'b101:  w_loadValue = {16'h0000, w_laneHalf};
            default: w_loadValue = bus_rdata;
        endcase
    end

    // Bus outputs are registered at capture and held untouched for the whole WAIT phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busReq   <= 1'b0;
            r_busWe    <= 1'b0;
            r_busAddr  <= 32'h0000_0000;
            r_busWdata <= 32'h0000_0000;
            r_busWstrb <= 4'b0000;
            r_lane     <= 2'b00;
            r_funct3   <= 3'b000;
            r_readData <= 32'h0000_0000;
        end else begin
            if (w_capture) begin
                r_busReq   <= 1'b1;
                r_busWe    <= mem_write_enable;
                r_busAddr  <= {w_addr[31:2], 2'b00};
                r_busWdata <= w_wdata;
                r_busWstrb <= w_wstrb;
                r_lane     <= w_addr[1:0];
                r_funct3   <= w_accessF3;
            end
            if (w_complete || w_timeout) begin
                r_busReq <= 1'b0;
            end
            if (w_complete && !r_busWe) begin
                r_readData <= w_loadValue;
            end else if (w_timeout && !r_busWe) begin
                r_readData <= 32'h0000_0000;
            end
        end
    end

`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam int CountWidth = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CountWidth-1:0] r_waitCount;
    logic                  r_busError;

    assign w_timeoutHit = (r_waitCount == CountWidth'(TIMEOUT_CYCLES));

    // The counter holds the number of WAIT cycles already spent without an ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_waitCount <= '0;
            r_busError  <= 1'b0;
        end else begin
            r_busError <= w_timeout;
            if (w_capture) begin
                r_waitCount <= '0;
            end else if (r_state == ST_WAIT && !bus_ack) begin
                r_waitCount <= r_waitCount + CountWidth'(1);
            end
        end
    end

    assign bus_error = r_busError;
`else
    logic w_unusedTimeoutParam;

    assign w_unusedTimeoutParam = (TIMEOUT_CYCLES == 0);
    assign w_timeoutHit         = 1'b0;
`endif

    assign bus_req   = r_busReq;
    assign bus_we    = r_busWe;
    assign bus_addr  = r_busAddr;
    assign bus_wdata = r_busWdata;
    assign bus_wstrb = r_busWstrb;
    assign read_data = r_readData;

endmodule

// File: tb/tb_multicycle_mem_bridge.sv
// Directed scoreboard bench for multicycle_mem_bridge; the watchdog scenario is built only
// when MEM_BRIDGE_TIMEOUT_EN is defined.
module tb_multicycle_mem_bridge;

    localparam int unsigned TbTimeout = 4;

    logic        clock;
    logic        reset;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic        inst_or_data;
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic [2:0]  funct3;
    logic        stall;
    logic [31:0] read_data;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    logic        bus_error;
`endif

    multicycle_mem_bridge #(
        .TIMEOUT_CYCLES(TbTimeout)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .mem_read_enable (mem_read_enable),
        .mem_write_enable(mem_write_enable),
        .inst_or_data    (inst_or_data),
        .pc              (pc),
        .alu_out         (alu_out),
        .store_data      (store_data),
        .funct3          (funct3),
        .stall           (stall),
        .read_data       (read_data),
        .bus_req         (bus_req),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_wstrb       (bus_wstrb),
        .bus_ack         (bus_ack),
        .bus_rdata       (bus_rdata)
`ifdef MEM_BRIDGE_TIMEOUT_EN
        ,
        .bus_error       (bus_error)
`endif
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } busReq_t;

    busReq_t     reqQ[$];
    logic [31:0] readQ[$];

    int          checks = 0;
    int          errors = 0;
    int          txCount = 0;
    logic        prevReq = 1'b0;
    logic [31:0] lastRead = 32'h0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts bus transactions as rising edges of bus_req seen at falling clock edges.
    always @(negedge clock) begin
        if (bus_req && !prevReq) txCount++;
        prevReq = bus_req;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelLoad(input logic iod, input logic [2:0] f3,
                                              input logic [1:0] lane, input logic [31:0] word);
        logic [31:0] byteShift;
        logic [31:0] halfShift;
        byteShift = word >> (8 * int'(lane));
        halfShift = lane[1] ? (word >> 16) : word;
        if (!iod) return word;
        case (f3)
            3'b000:  return {{24{byteShift[7]}}, byteShift[7:0]};
            3'b001:  return {{16{halfShift[15]}}, halfShift[15:0]};
            3'b100:  return {24'h0, byteShift[7:0]};
            3'b101:  return {16'h0, halfShift[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic busReq_t modelRequest(input logic wr, input logic iod, input logic [2:0] f3,
                                             input logic [31:0] addr, input logic [31:0] sdata);
        busReq_t r;
        r.we    = wr;
        r.addr  = addr & 32'hFFFF_FFFC;
        r.wstrb = 4'b0000;
        r.wdata = sdata;
        if (wr) begin
            if (iod && f3 == 3'b000) begin
                case (addr[1:0])
                    2'd0: r.wstrb = 4'b0001;
                    2'd1: r.wstrb = 4'b0010;
                    2'd2: r.wstrb = 4'b0100;
                    default: r.wstrb = 4'b1000;
                endcase
                r.wdata = {sdata[7:0], sdata[7:0], sdata[7:0], sdata[7:0]};
            end else if (iod && f3 == 3'b001) begin
                r.wstrb = addr[1] ? 4'b1100 : 4'b0011;
                r.wdata = {sdata[15:0], sdata[15:0]};
            end else begin
                r.wstrb = 4'b1111;
            end
        end
        return r;
    endfunction

    // One complete transaction: drive, hold through WAIT (scrambling ignored inputs), ack, DONE, IDLE.
    task automatic applyStimulus(input string tag, input logic rd, input logic wr, input logic iod,
                                 input logic [31:0] addr, input logic [31:0] sdata, input logic [2:0] f3,
                                 input int ackDelay, input logic [31:0] rdata);
        busReq_t expReq;
        int      stallCycles;
        int      txBefore;
        reqQ.push_back(modelRequest(wr, iod, f3, addr, sdata));
        if (rd && !wr) lastRead = modelLoad(iod, f3, addr[1:0], rdata);
        readQ.push_back(lastRead);

        @(posedge clock); #1;
        txBefore         = txCount;
        mem_read_enable  = rd;
        mem_write_enable = wr;
        inst_or_data     = iod;
        pc               = iod ? $urandom : addr;
        alu_out          = iod ? addr : $urandom;
        store_data       = sdata;
        funct3           = f3;
        @(negedge clock);
        checkOutput({tag, " stall idle"}, stall, 1);
        checkOutput({tag, " req idle"}, bus_req, 0);
        stallCycles = 1;

        @(posedge clock); #1;
        expReq = reqQ.pop_front();
        for (int i = 0; i <= ackDelay; i++) begin
            if (i > 0) begin
                pc               = $urandom;
                alu_out          = $urandom;
                store_data       = $urandom;
                funct3           = 3'($urandom);
                inst_or_data     = 1'($urandom);
                mem_read_enable  = 1'($urandom);
                mem_write_enable = 1'($urandom);
            end
            if (i == ackDelay) begin
                bus_ack   = 1'b1;
                bus_rdata = rdata;
            end
            @(negedge clock);
            if (stall) stallCycles++;
            checkOutput({tag, " req wait"}, bus_req, 1);
            checkOutput({tag, " we"}, bus_we, expReq.we);
            checkOutput({tag, " addr"}, bus_addr, expReq.addr);
            checkOutput({tag, " wstrb"}, bus_wstrb, expReq.wstrb);
            if (expReq.we) checkOutput({tag, " wdata"}, bus_wdata, expReq.wdata);
            @(posedge clock); #1;
        end

        bus_ack          = 1'b0;
        bus_rdata        = $urandom;
        mem_read_enable  = rd;
        mem_write_enable = wr;
        @(negedge clock);
        checkOutput({tag, " stall done"}, stall, 0);
        checkOutput({tag, " req done"}, bus_req, 0);
        checkOutput({tag, " read_data"}, read_data, readQ.pop_front());
        checkOutput({tag, " stall cycles"}, 32'(stallCycles), 32'(ackDelay + 2));

        @(posedge clock); #1;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        @(negedge clock);
        checkOutput({tag, " no reissue"}, bus_req, 0);
        checkOutput({tag, " tx count"}, 32'(txCount - txBefore), 1);
    endtask

    initial begin
        reset            = 1'b1;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        inst_or_data     = 1'b0;
        pc               = 32'h0;
        alu_out          = 32'h0;
        store_data       = 32'h0;
        funct3           = 3'b000;
        bus_ack          = 1'b0;
        bus_rdata        = 32'h0;

        @(negedge clock);
        checkOutput("reset req", bus_req, 0);
        checkOutput("reset we", bus_we, 0);
        checkOutput("reset addr", bus_addr, 0);
        checkOutput("reset wdata", bus_wdata, 0);
        checkOutput("reset wstrb", bus_wstrb, 0);
        checkOutput("reset read_data", read_data, 0);
        checkOutput("reset stall", stall, 0);
        #2 reset = 1'b0;

        applyStimulus("fetch", 1, 0, 0, 32'h0000_0100, 32'h0, 3'b000, 0, 32'h0050_0093);
        applyStimulus("lb", 1, 0, 1, 32'h0000_0203, 32'h0, 3'b000, 0, 32'h80FF_FFFF);
        applyStimulus("lbu", 1, 0, 1, 32'h0000_0203, 32'h0, 3'b100, 1, 32'h80FF_FFFF);
        applyStimulus("lhu", 1, 0, 1, 32'h0000_0202, 32'h0, 3'b101, 0, 32'h80FF_FFFF);
        applyStimulus("lh", 1, 0, 1, 32'h0000_0301, 32'h0, 3'b001, 2, 32'h1234_8001);
        applyStimulus("lw misaligned", 1, 0, 1, 32'h0000_0407, 32'h0, 3'b010, 0, 32'hCAFE_F00D);
        applyStimulus("undef f3", 1, 0, 1, 32'h0000_0405, 32'h0, 3'b111, 0, 32'h8765_4321);
        applyStimulus("sh", 0, 1, 1, 32'h0000_0102, 32'h1234_ABCD, 3'b001, 5, 32'h0);
        applyStimulus("sb", 0, 1, 1, 32'h0000_0101, 32'h0000_00EF, 3'b000, 0, 32'h0);
        applyStimulus("sw", 0, 1, 1, 32'h0000_020A, 32'hDEAD_BEEF, 3'b010, 1, 32'h0);
        applyStimulus("both enables", 1, 1, 1, 32'h0000_0504, 32'h0BAD_CAFE, 3'b010, 0, 32'h1111_1111);

        // A stray ack with no request pending must not start anything.
        @(posedge clock); #1;
        bus_ack = 1'b1;
        @(negedge clock);
        checkOutput("stray ack req", bus_req, 0);
        checkOutput("stray ack stall", stall, 0);
        @(posedge clock); #1;
        bus_ack = 1'b0;
        @(negedge clock);
        checkOutput("stray ack idle", bus_req, 0);

        // Reset in the middle of WAIT abandons the transaction immediately.
        @(posedge clock); #1;
        mem_read_enable = 1'b1;
        inst_or_data    = 1'b0;
        pc              = 32'h0000_0600;
        @(posedge clock); #1;
        @(negedge clock);
        checkOutput("pre-reset req", bus_req, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset req", bus_req, 0);
        checkOutput("async reset addr", bus_addr, 0);
        checkOutput("async reset read_data", read_data, 0);
        mem_read_enable = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        lastRead = 32'h0;
        applyStimulus("post-reset", 1, 0, 0, 32'h0000_0700, 32'h0, 3'b000, 0, 32'h0FED_CBA9);

`ifdef MEM_BRIDGE_TIMEOUT_EN
        begin
            int released;
            int errPulses;
            released  = 0;
            errPulses = 0;
            @(posedge clock); #1;
            mem_read_enable = 1'b1;
            inst_or_data    = 1'b1;
            alu_out         = 32'h0000_0800;
            funct3          = 3'b010;
            for (int i = 0; i < 40 && released == 0; i++) begin
                @(posedge clock); #1;
                @(negedge clock);
                if (bus_error) errPulses++;
                if (!stall) begin
                    released = 1;
                    checkOutput("timeout error", bus_error, 1);
                    checkOutput("timeout read_data", read_data, 0);
                    checkOutput("timeout req", bus_req, 0);
                end
            end
            checkOutput("timeout released", 32'(released), 1);
            @(posedge clock); #1;
            mem_read_enable = 1'b0;
            @(negedge clock);
            if (bus_error) errPulses++;
            checkOutput("timeout pulses", 32'(errPulses), 1);
            checkOutput("timeout idle", bus_req, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
